uart_rx_sampler: RTL and testbench
==================================

// Module: uart_rx_sampler
// PURPOSE
// - Receive front end feeding the RX word shift register: converts an asynchronous serial line
//   (1 start, word_size data LSB first, 1 stop, no parity) into per-bit (bit, strobe) pairs.
// - bit_out drives bit_to_UART and bit_strobe drives external_clk of the UART block, so the RX
//   shift register captures exactly word_size bits per frame, LSB first.
// - Single clock domain (internal_clk); oversamples the line and rejects false starts and bad stops.
// PARAMETERS
// - word_size   8   data bits per frame
// - OVERSAMPLE  16  sample ticks per bit period; even, >= 4
// - CLK_DIV     27  internal_clk cycles per sample tick; >= 2 (50 MHz / (115200*16))
// PORTS
// - internal_clk  in   1  sole clock, all state on posedge
// - rst           in   1  synchronous, active-high reset
// - rx_line       in   1  raw asynchronous serial input, idle high
// - bit_out       out  1  last sampled data bit, to bit_to_UART
// - bit_strobe    out  1  one-cycle pulse per data bit, to external_clk
// - frame_done    out  1  one-cycle pulse: valid stop bit seen
// - frame_error   out  1  one-cycle pulse: stop bit sampled low
// - busy          out  1  high whenever FSM is not IDLE
// BEHAVIOUR
// - Clocking: internal_clk only. Reset: rst, synchronous, active-high.
// - Reset values: bit_out=0, bit_strobe=0, frame_done=0, frame_error=0, busy=0. Synchroniser
//   flops reset to 1. FSM=IDLE. All counters 0. rst mid-frame aborts: no strobe or pulse is emitted
//   for the aborted frame.
// - rx_line passes through a 2-flop synchroniser (rx_s); all decisions use rx_s only.
// - Tick: div counter 0..CLK_DIV-1, tick pulses when count==CLK_DIV-1. Counts only outside IDLE.
//   Cleared on the IDLE->START transition so sample phase aligns to the start edge.
// - Sample counter 0..OVERSAMPLE-1 advances on each tick and wraps. Bit index 0..word_size-1.
// - IDLE: rx_s==0 -> START, clear all counters.
// - START: at the tick where sample count reaches OVERSAMPLE/2-1 (mid start bit):
//   - rx_s==0 -> DATA; clear sample counter.
//   - rx_s==1 -> IDLE (false start/glitch); no outputs.
// - DATA: at each tick with sample count==OVERSAMPLE-1 (mid bit):
//   - bit_out<=rx_s in that cycle (cycle N); bit_strobe=1 in cycle N+1 only.
//   - bit_out is therefore stable >=1 cycle before the strobe rising edge and held until the next sample.
//   - bit index increments; after bit word_size-1 -> STOP.
// - STOP: at the tick with sample count==OVERSAMPLE-1:
//   - rx_s==1 -> frame_done pulse (1 cycle), then IDLE.
//   - rx_s==0 -> frame_error pulse (1 cycle), then WAIT_IDLE.
// - WAIT_IDLE: stay until rx_s==1, then IDLE (break/framing recovery); no strobes.
// - Back-to-back frames: the start edge immediately after the mid-stop sample is accepted; the
//   new START begins the cycle after IDLE sees rx_s==0.
// - Exactly word_size strobes per accepted start bit, independent of stop-bit outcome.
// - Counter widths: div $clog2(CLK_DIV), sample $clog2(OVERSAMPLE), bit index $clog2(word_size).
//   No counter may overflow past its terminal value.
// STRUCTURE
// - uart_pkg: typedef enum {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t, plus defaults
//   UART_OVERSAMPLE=16 and UART_CLK_DIV=27, shared with the future TX serialiser.
// - Sub-module uart_baud_tick (CLK_DIV; inputs internal_clk, rst, clear, en; output tick).
//   The TX side reuses it.
// - All other logic lives in uart_rx_sampler: synchroniser, FSM, counters, output registers.
// TESTING (CLK_DIV=2, OVERSAMPLE=16, word_size=8; bit period = 32 cycles)
// - Frame 0xA5 with good stop -> 8 strobes, bit_out = 1,0,1,0,0,1,0,1 at the strobes;
//   one frame_done pulse; busy drops after the stop bit.
// - 3-tick low glitch on idle line -> zero strobes, no frame_done/frame_error; busy back to 0
//   within OVERSAMPLE/2 ticks.
// - Frame 0x5A with stop bit held low for 2 bit periods -> 8 strobes, one frame_error pulse,
//   no frame_done; busy stays 1 until the line returns high.
// - rst asserted after the 3rd data bit of a frame -> all outputs 0 the next cycle, no further
//   strobes. Following frame 0x3C is received correctly with 8 strobes and one frame_done.
// - Back-to-back 0x00 then 0xFF, no idle gap -> 16 strobes, two frame_done pulses, correct bit values.
// - Assertion on every strobe: bit_out unchanged in the cycle before and the cycle of bit_strobe.
//   bit_strobe is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and default timing
// parameters, used by both the RX sampler and the future TX serialiser.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_CLK_DIV    = 27;

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: one-cycle tick every CLK_DIV enabled cycles.
// The clear input realigns the phase to an external event such as a start edge.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = UART_CLK_DIV
) (
    input  logic internal_clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;

    assign tick = en && (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (clear) begin
            div_d = '0;
        end else if (en) begin
            div_d = tick ? '0 : div_q + DW'(1);
        end
    end

    always_ff @(posedge internal_clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: oversamples an asynchronous serial line and emits one
// (bit_out, bit_strobe) pair per data bit, plus frame_done / frame_error pulses.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned word_size  = 8,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned CLK_DIV    = UART_CLK_DIV
) (
    input  logic internal_clk,
    input  logic rst,
    input  logic rx_line,
    output logic bit_out,
    output logic bit_strobe,
    output logic frame_done,
    output logic frame_error,
    output logic busy
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (word_size > 1) ? $clog2(word_size) : 1;
    localparam logic [SW-1:0] SAMPLE_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(word_size - 1);

    rx_state_t state_q, state_d;

    logic          rx_meta_q, rx_s_q;
    logic [SW-1:0] sample_q, sample_d;
    logic [BW-1:0] bit_idx_q, bit_idx_d;
    logic          bit_out_q, bit_out_d;
    logic          strobe_pend_q, strobe_pend_d;
    logic          bit_strobe_q;
    logic          frame_done_q, frame_done_d;
    logic          frame_error_q, frame_error_d;

    logic tick, div_clear, div_en;

    assign div_en    = (state_q != IDLE);
    assign div_clear = (state_q == IDLE) && !rx_s_q;

    uart_baud_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_baud_tick (
        .internal_clk(internal_clk),
        .rst         (rst),
        .clear       (div_clear),
        .en          (div_en),
        .tick        (tick)
    );

    always_ff @(posedge internal_clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_line;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        sample_d      = sample_q;
        bit_idx_d     = bit_idx_q;
        bit_out_d     = bit_out_q;
        strobe_pend_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;

        if (tick) begin
            sample_d = (sample_q == SAMPLE_LAST) ? '0 : sample_q + SW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d   = START;
                    sample_d  = '0;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (tick && sample_q == SAMPLE_MID) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DATA;
                        sample_d = '0;
                    end
                end
            end
            DATA: begin
                // bit_out is registered here; the strobe follows one cycle later
                // so the downstream shift register always sees settled data.
                if (tick && sample_q == SAMPLE_LAST) begin
                    bit_out_d     = rx_s_q;
                    strobe_pend_d = 1'b1;
                    if (bit_idx_q == BIT_LAST) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
            end
            STOP: begin
                if (tick && sample_q == SAMPLE_LAST) begin
                    if (rx_s_q) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge internal_clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sample_q      <= '0;
            bit_idx_q     <= '0;
            bit_out_q     <= 1'b0;
            strobe_pend_q <= 1'b0;
            bit_strobe_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sample_q      <= sample_d;
            bit_idx_q     <= bit_idx_d;
            bit_out_q     <= bit_out_d;
            strobe_pend_q <= strobe_pend_d;
            bit_strobe_q  <= strobe_pend_q;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign bit_out     = bit_out_q;
    assign bit_strobe  = bit_strobe_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: serialises frames onto rx_line and
// checks strobed bits against a queue of expected data bits.
module tb_uart_rx_sampler;

    localparam int unsigned WS      = 8;
    localparam int unsigned OS      = 16;
    localparam int unsigned DIV     = 2;
    localparam int unsigned BIT_CYC = OS * DIV;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic rx_line = 1'b1;
    logic bit_out, bit_strobe, frame_done, frame_error, busy;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int done_cnt   = 0;
    int err_cnt    = 0;

    logic exp_q[$];
    logic prev_strobe  = 1'b0;
    logic prev_bit_out = 1'b0;

    always #5 clk = ~clk;

    uart_rx_sampler #(
        .word_size (WS),
        .OVERSAMPLE(OS),
        .CLK_DIV   (DIV)
    ) dut (
        .internal_clk(clk),
        .rst         (rst),
        .rx_line     (rx_line),
        .bit_out     (bit_out),
        .bit_strobe  (bit_strobe),
        .frame_done  (frame_done),
        .frame_error (frame_error),
        .busy        (busy)
    );

    // Strobe monitor: pops the scoreboard and checks strobe/bit_out timing.
    always @(negedge clk) begin
        logic exp_bit;
        if (bit_strobe === 1'b1) begin
            strobe_cnt++;
            checks++;
            assert (prev_strobe === 1'b0) else begin
                errors++;
                $error("FAIL strobe_width: observed prev_strobe=%0b expected 0", prev_strobe);
            end
            checks++;
            assert (bit_out === prev_bit_out) else begin
                errors++;
                $error("FAIL bit_out_stable: observed %0b expected %0b", bit_out, prev_bit_out);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL sb_underflow: observed strobe with bit_out=%0b expected no strobe", bit_out);
            end else begin
                exp_bit = exp_q.pop_front();
                assert (bit_out === exp_bit) else begin
                    errors++;
                    $error("FAIL sb_bit: observed %0b expected %0b", bit_out, exp_bit);
                end
            end
        end
        if (frame_done === 1'b1)  done_cnt++;
        if (frame_error === 1'b1) err_cnt++;
        prev_strobe  = bit_strobe;
        prev_bit_out = bit_out;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int stop_cycles, input logic stop_val);
        logic [7:0] data;
        data = d;
        rx_line = 1'b0;
        cycles(BIT_CYC);
        check("busy_in_frame", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(data[i]);
            rx_line = data[i];
            cycles(BIT_CYC);
        end
        rx_line = stop_val;
        cycles(stop_cycles);
    endtask

    initial begin
        int s0, d0, e0;
        logic [7:0] pre;

        rst = 1'b1;
        rx_line = 1'b1;
        cycles(4);
        check("reset_outputs", {27'b0, bit_out, bit_strobe, frame_done, frame_error, busy}, 32'd0);
        rst = 1'b0;
        cycles(BIT_CYC);
        check("idle_busy", {31'b0, busy}, 32'd0);

        // Good frame 0xA5
        s0 = strobe_cnt; d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hA5, BIT_CYC, 1'b1);
        check("a5_busy_after", {31'b0, busy}, 32'd0);
        check("a5_strobes", strobe_cnt - s0, 32'd8);
        check("a5_done", done_cnt - d0, 32'd1);
        check("a5_error", err_cnt - e0, 32'd0);
        check("a5_queue", exp_q.size(), 32'd0);

        // 3-tick glitch on idle line
        cycles(BIT_CYC);
        s0 = strobe_cnt; d0 = done_cnt; e0 = err_cnt;
        rx_line = 1'b0;
        cycles(3 * DIV);
        rx_line = 1'b1;
        cycles(3);
        check("glitch_busy_high", {31'b0, busy}, 32'd1);
        cycles(14);
        check("glitch_busy_low", {31'b0, busy}, 32'd0);
        cycles(BIT_CYC);
        check("glitch_strobes", strobe_cnt - s0, 32'd0);
        check("glitch_done", done_cnt - d0, 32'd0);
        check("glitch_error", err_cnt - e0, 32'd0);

        // Frame 0x5A with stop held low for two bit periods
        s0 = strobe_cnt; d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h5A, 2 * BIT_CYC, 1'b0);
        check("break_busy_held", {31'b0, busy}, 32'd1);
        check("break_strobes", strobe_cnt - s0, 32'd8);
        check("break_error", err_cnt - e0, 32'd1);
        check("break_done", done_cnt - d0, 32'd0);
        rx_line = 1'b1;
        cycles(5);
        check("break_busy_release", {31'b0, busy}, 32'd0);
        cycles(BIT_CYC);

        // Reset during data bit 3 of frame 0x07
        s0 = strobe_cnt; d0 = done_cnt; e0 = err_cnt;
        pre = 8'h07;
        rx_line = 1'b0;
        cycles(BIT_CYC);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(pre[i]);
            rx_line = pre[i];
            cycles(BIT_CYC);
        end
        rx_line = pre[3];
        cycles(8);
        check("pre_rst_state", {30'b0, bit_out, busy}, 32'd3);
        rst = 1'b1;
        cycles(1);
        check("rst_outputs", {27'b0, bit_out, bit_strobe, frame_done, frame_error, busy}, 32'd0);
        rx_line = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(10 * BIT_CYC);
        check("abort_strobes", strobe_cnt - s0, 32'd3);
        check("abort_done", done_cnt - d0, 32'd0);
        check("abort_error", err_cnt - e0, 32'd0);
        check("abort_queue", exp_q.size(), 32'd0);

        s0 = strobe_cnt; d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h3C, BIT_CYC, 1'b1);
        cycles(BIT_CYC);
        check("3c_strobes", strobe_cnt - s0, 32'd8);
        check("3c_done", done_cnt - d0, 32'd1);
        check("3c_error", err_cnt - e0, 32'd0);

        // Back-to-back 0x00 then 0xFF
        s0 = strobe_cnt; d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h00, BIT_CYC, 1'b1);
        send_frame(8'hFF, BIT_CYC, 1'b1);
        cycles(BIT_CYC);
        check("b2b_strobes", strobe_cnt - s0, 32'd16);
        check("b2b_done", done_cnt - d0, 32'd2);
        check("b2b_error", err_cnt - e0, 32'd0);
        check("b2b_busy", {31'b0, busy}, 32'd0);
        check("b2b_queue", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
